// File: rtl/timer_controller_if.sv
// Front-panel / datapath bundle seen by the timer sequencing controller.
// master: the side that drives switch, buttons and display (panel + datapath).
// slave:  the controller itself.
interface timer_controller_if;
   logic [1:0]  switch_state;
   logic        button_left;
   logic        button_right;
   logic        button_increase;
   logic        button_decrease;
   logic [23:0] timer_display;
   logic [23:0] intended_set_timer;
   logic        timer_propagate;
   logic        cmd_start;
   logic        cmd_pause;
   logic        cmd_clear;
   logic [2:0]  digit_sel;
   logic        timer_alarm;
   logic [2:0]  ctrl_state;

   modport master (
      output switch_state, button_left, button_right, button_increase,
             button_decrease, timer_display,
      input  intended_set_timer, timer_propagate, cmd_start, cmd_pause,
             cmd_clear, digit_sel, timer_alarm, ctrl_state
   );

   modport slave (
      input  switch_state, button_left, button_right, button_increase,
             button_decrease, timer_display,
      output intended_set_timer, timer_propagate, cmd_start, cmd_pause,
             cmd_clear, digit_sel, timer_alarm, ctrl_state
   );
endinterface

// File: rtl/timer_controller.sv
// Countdown-timer sequencing controller: preset editing, load strobe,
// start/pause/clear commands and expiry/alarm handling.
// Optional build macro TIMER_CTRL_ALARM_TIMEOUT_EN: alarm self-clears after
// ALARM_CYCLES clocks in DONE; otherwise it holds until a button or reset.
//
// state | meaning
// SET   | editing preset digits, cursor on digit_sel
// PROP  | timer_propagate held high, editing blocked
// READY | preset loaded, waiting for start
// RUN   | datapath counting, watching for expiry
// PAUSE | datapath halted, waiting for resume
// DONE  | expired, timer_alarm high
module timer_controller #(
   parameter int unsigned PROP_CYCLES  = 1,
   parameter int unsigned ALARM_CYCLES = 250000000
) (
   input  logic               clk_i,
   input  logic               reset_i,
   timer_controller_if.slave  bus
);

   typedef enum logic [2:0] {
      S_SET   = 3'd0,
      S_PROP  = 3'd1,
      S_READY = 3'd2,
      S_RUN   = 3'd3,
      S_PAUSE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      state_q;
   logic [23:0] preset_q;
   logic [2:0]  sel_q;
   logic [3:0]  prop_cnt_q;
   logic        prop_q, start_q, pause_q, clear_q, alarm_q, armed_q;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
   logic [27:0] alarm_cnt_q;
`endif

   logic        btn_en, btn_inc, btn_dec, btn_left, btn_right, btn_any;
   logic [4:0]  shamt;
   logic [3:0]  cur_digit, digit_max, digit_up, digit_dn;
   logic [23:0] clear_mask, preset_up_d, preset_dn_d;
   logic        expired;

   // Gate buttons on timer mode and keep only the highest-priority press.
   always_comb begin
      btn_en    = (bus.switch_state == 2'b10);
      btn_inc   = btn_en & bus.button_increase;
      btn_dec   = btn_en & bus.button_decrease & ~bus.button_increase;
      btn_left  = btn_en & bus.button_left & ~bus.button_increase & ~bus.button_decrease;
      btn_right = btn_en & bus.button_right & ~bus.button_increase & ~bus.button_decrease
                  & ~bus.button_left;
      btn_any   = btn_en & (bus.button_left | bus.button_right | bus.button_increase
                  | bus.button_decrease);
   end

   // Wrapped +1/-1 of the digit under the cursor; tens of min/sec wrap at 5.
   always_comb begin
      shamt       = 5'd20 - {sel_q, 2'b00};
      cur_digit   = 4'(preset_q >> shamt);
      digit_max   = (sel_q == 3'd2 || sel_q == 3'd4) ? 4'd5 : 4'd9;
      digit_up    = (cur_digit >= digit_max) ? 4'd0 : cur_digit + 4'd1;
      digit_dn    = (cur_digit == 4'd0 || cur_digit > digit_max) ? digit_max
                                                                 : cur_digit - 4'd1;
      clear_mask  = ~(24'hF << shamt);
      preset_up_d = (preset_q & clear_mask) | (24'(digit_up) << shamt);
      preset_dn_d = (preset_q & clear_mask) | (24'(digit_dn) << shamt);
      expired     = armed_q && (bus.timer_display == 24'h000000);
   end

   // Sequencing FSM with registered strobes and outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_SET;
         preset_q   <= '0;
         sel_q      <= '0;
         prop_cnt_q <= '0;
         prop_q     <= 1'b0;
         start_q    <= 1'b0;
         pause_q    <= 1'b0;
         clear_q    <= 1'b0;
         alarm_q    <= 1'b0;
         armed_q    <= 1'b0;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
         alarm_cnt_q <= '0;
`endif
      end else begin
         start_q <= 1'b0;
         pause_q <= 1'b0;
         clear_q <= 1'b0;
         armed_q <= 1'b0;
         case (state_q)
            S_SET: begin
               if (btn_inc) begin
                  preset_q <= preset_up_d;
               end else if (btn_dec) begin
                  preset_q <= preset_dn_d;
               end else if (btn_left) begin
                  sel_q <= (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
               end else if (btn_right && preset_q != 24'h000000) begin
                  state_q    <= S_PROP;
                  prop_q     <= 1'b1;
                  prop_cnt_q <= 4'(PROP_CYCLES - 1);
               end
            end
            S_PROP: begin
               if (prop_cnt_q == 4'd0) begin
                  prop_q  <= 1'b0;
                  state_q <= S_READY;
               end else begin
                  prop_cnt_q <= prop_cnt_q - 4'd1;
               end
            end
            S_READY, S_PAUSE: begin
               if (btn_left) begin
                  start_q <= 1'b1;
                  state_q <= S_RUN;
               end else if (btn_inc) begin
                  clear_q <= 1'b1;
                  state_q <= S_SET;
               end
            end
            S_RUN: begin
               if (btn_inc) begin
                  clear_q <= 1'b1;
                  state_q <= S_SET;
               end else if (btn_dec) begin
                  pause_q <= 1'b1;
                  state_q <= S_PAUSE;
               end else if (expired) begin
                  alarm_q <= 1'b1;
                  state_q <= S_DONE;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
                  alarm_cnt_q <= 28'(ALARM_CYCLES - 1);
`endif
               end else begin
                  // A nonzero display proves the load reached the datapath.
                  armed_q <= armed_q | (bus.timer_display != 24'h000000);
               end
            end
            S_DONE: begin
               if (btn_any) begin
                  clear_q <= 1'b1;
                  alarm_q <= 1'b0;
                  state_q <= S_SET;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
               end else if (alarm_cnt_q == 28'd0) begin
                  clear_q <= 1'b1;
                  alarm_q <= 1'b0;
                  state_q <= S_SET;
               end else begin
                  alarm_cnt_q <= alarm_cnt_q - 28'd1;
`endif
               end
            end
            default: state_q <= S_SET;
         endcase
      end
   end

   assign bus.intended_set_timer = preset_q;
   assign bus.timer_propagate    = prop_q;
   assign bus.cmd_start          = start_q;
   assign bus.cmd_pause          = pause_q;
   assign bus.cmd_clear          = clear_q;
   assign bus.digit_sel          = sel_q;
   assign bus.timer_alarm        = alarm_q;
   assign bus.ctrl_state         = state_q;

endmodule
